// File: rtl/cpu6502_interrupt_sequencer_pkg.sv
// rtl/cpu6502_interrupt_sequencer_pkg.sv - shared encodings for the 6502 interrupt entry sequencer
package cpu6502_interrupt_pkg;

    typedef enum logic [2:0] {
        SRC_NONE  = 3'd0,
        SRC_RESET = 3'd1,
        SRC_NMI   = 3'd2,
        SRC_IRQ   = 3'd3,
        SRC_BRK   = 3'd4
    } src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } state_e;

    localparam logic [2:0] STEP_DUMMY0    = 3'd0;
    localparam logic [2:0] STEP_DUMMY1    = 3'd1;
    localparam logic [2:0] STEP_PUSH_PCH  = 3'd2;
    localparam logic [2:0] STEP_PUSH_PCL  = 3'd3;
    localparam logic [2:0] STEP_PUSH_P    = 3'd4;
    localparam logic [2:0] STEP_VECTOR_LO = 3'd5;
    localparam logic [2:0] STEP_VECTOR_HI = 3'd6;

    localparam logic [1:0] SEL_PCH = 2'd0;
    localparam logic [1:0] SEL_PCL = 2'd1;
    localparam logic [1:0] SEL_P   = 2'd2;

    localparam logic [15:0] DEFAULT_VECTOR_NMI   = 16'hFFFA;
    localparam logic [15:0] DEFAULT_VECTOR_RESET = 16'hFFFC;
    localparam logic [15:0] DEFAULT_VECTOR_IRQ   = 16'hFFFE;

    // Steps during which a late NMI can still take over the vector fetch.
    function automatic logic in_hijack_window(input logic [2:0] step);
        return (step == STEP_DUMMY0) || (step == STEP_DUMMY1) ||
               (step == STEP_PUSH_PCH) || (step == STEP_PUSH_PCL);
    endfunction

endpackage

// File: rtl/cpu6502_interrupt_sequencer_if.sv
// rtl/cpu6502_interrupt_sequencer_if.sv - core <-> interrupt sequencer control bundle
interface cpu6502_interrupt_sequencer_if;
    logic        enable;
    logic        interrupt_N;
    logic        nonMaskableInterrupt_N;
    logic        interruptDisableFlag;
    logic        instructionBoundary;
    logic        brkDecoded;
    logic        busy;
    logic [2:0]  sequenceStep;
    logic        stackWrite;
    logic [1:0]  stackSelect;
    logic        pushBreakFlag;
    logic        vectorFetch;
    logic [15:0] vectorAddress;
    logic        incrementPc;
    logic        setInterruptDisable;
    logic        sequenceDone;

    modport master (
        output enable, interrupt_N, nonMaskableInterrupt_N, interruptDisableFlag,
               instructionBoundary, brkDecoded,
        input  busy, sequenceStep, stackWrite, stackSelect, pushBreakFlag, vectorFetch,
               vectorAddress, incrementPc, setInterruptDisable, sequenceDone
    );

    modport slave (
        input  enable, interrupt_N, nonMaskableInterrupt_N, interruptDisableFlag,
               instructionBoundary, brkDecoded,
        output busy, sequenceStep, stackWrite, stackSelect, pushBreakFlag, vectorFetch,
               vectorAddress, incrementPc, setInterruptDisable, sequenceDone
    );
endinterface

// File: rtl/cpu6502_interrupt_sequencer_nmi_edge_detect.sv
// rtl/cpu6502_interrupt_sequencer_nmi_edge_detect.sv - NMI falling-edge detector with pending latch
module cpu6502_nmi_edge_detect (
    input  logic clock,
    input  logic reset_N,
    input  logic nmi_n,
    input  logic clear,
    output logic pending
);
    logic sample_q, sample_d;
    logic pending_q, pending_d;

    // A fresh edge wins over a simultaneous clear so it is never lost.
    always_comb begin
        sample_d  = nmi_n;
        pending_d = pending_q;
        if (sample_q && !nmi_n) begin
            pending_d = 1'b1;
        end else if (clear) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            sample_q  <= 1'b1;
            pending_q <= 1'b0;
        end else begin
            sample_q  <= sample_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
endmodule

// File: rtl/cpu6502_interrupt_sequencer.sv
// rtl/cpu6502_interrupt_sequencer.sv - RESET/NMI/IRQ/BRK arbitration and 7-step entry sequence
// CPU6502_NMI_HIJACK_EN lets an NMI arriving early in an IRQ/BRK entry steal its vector.
module cpu6502_interrupt_sequencer
    import cpu6502_interrupt_pkg::*;
#(
    parameter logic [15:0] VECTOR_NMI   = DEFAULT_VECTOR_NMI,
    parameter logic [15:0] VECTOR_RESET = DEFAULT_VECTOR_RESET,
    parameter logic [15:0] VECTOR_IRQ   = DEFAULT_VECTOR_IRQ
) (
    input  logic                          clock,
    input  logic                          reset_N,
    cpu6502_interrupt_sequencer_if.slave  bus
);
    state_e     state_q, state_d;
    logic [2:0] step_q, step_d;
    src_e       src_q, src_d;
    logic       reset_pending_q, reset_pending_d;
    src_e       arb_src;
    logic       nmi_pending;
    logic       nmi_clear;
    logic       irq_active;
    logic       hijack;
    logic [15:0] vec_base;

    assign irq_active = !bus.interrupt_N && !bus.interruptDisableFlag;

    // The pending NMI is consumed as the sequence moves into its low vector fetch.
    assign nmi_clear = bus.enable && (state_q == ST_SEQ) && (step_q == STEP_PUSH_P) &&
                       ((src_q == SRC_NMI) || hijack);

    cpu6502_nmi_edge_detect u_nmi_edge (
        .clock   (clock),
        .reset_N (reset_N),
        .nmi_n   (bus.nonMaskableInterrupt_N),
        .clear   (nmi_clear),
        .pending (nmi_pending)
    );

`ifdef CPU6502_NMI_HIJACK_EN
    logic hijack_q, hijack_d;

    always_comb begin
        hijack_d = hijack_q;
        if (bus.enable) begin
            if (state_q == ST_IDLE) begin
                hijack_d = 1'b0;
            end else if (((src_q == SRC_IRQ) || (src_q == SRC_BRK)) &&
                         in_hijack_window(step_q) && nmi_pending) begin
                hijack_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            hijack_q <= 1'b0;
        end else begin
            hijack_q <= hijack_d;
        end
    end

    assign hijack = hijack_q;
`else
    assign hijack = 1'b0;
`endif

    always_comb begin
        arb_src = SRC_NONE;
        if (reset_pending_q) begin
            arb_src = SRC_RESET;
        end else if (nmi_pending) begin
            arb_src = SRC_NMI;
        end else if (irq_active) begin
            arb_src = SRC_IRQ;
        end else if (bus.brkDecoded) begin
            arb_src = SRC_BRK;
        end
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_q         <= ST_IDLE;
            step_q          <= STEP_DUMMY0;
            src_q           <= SRC_NONE;
            reset_pending_q <= 1'b1;
        end else begin
            state_q         <= state_d;
            step_q          <= step_d;
            src_q           <= src_d;
            reset_pending_q <= reset_pending_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        step_d          = step_q;
        src_d           = src_q;
        reset_pending_d = reset_pending_q;
        if (bus.enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.instructionBoundary && (arb_src != SRC_NONE)) begin
                        state_d = ST_SEQ;
                        step_d  = STEP_DUMMY0;
                        src_d   = arb_src;
                    end
                end
                ST_SEQ: begin
                    if (step_q == STEP_VECTOR_HI) begin
                        state_d = ST_IDLE;
                        step_d  = STEP_DUMMY0;
                        if (src_q == SRC_RESET) begin
                            reset_pending_d = 1'b0;
                        end
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        vec_base = VECTOR_IRQ;
        if (src_q == SRC_RESET) begin
            vec_base = VECTOR_RESET;
        end else if ((src_q == SRC_NMI) || hijack) begin
            vec_base = VECTOR_NMI;
        end
    end

    always_comb begin
        bus.busy                = 1'b0;
        bus.sequenceStep        = STEP_DUMMY0;
        bus.stackWrite          = 1'b0;
        bus.stackSelect         = SEL_PCH;
        bus.pushBreakFlag       = 1'b0;
        bus.vectorFetch         = 1'b0;
        bus.vectorAddress       = VECTOR_RESET;
        bus.incrementPc         = 1'b0;
        bus.setInterruptDisable = 1'b0;
        bus.sequenceDone        = 1'b0;
        if (state_q == ST_SEQ) begin
            bus.busy         = 1'b1;
            bus.sequenceStep = step_q;
            bus.incrementPc  = (step_q == STEP_DUMMY0) && (src_q == SRC_BRK);
            case (step_q)
                STEP_PUSH_PCH: begin
                    bus.stackSelect = SEL_PCH;
                    bus.stackWrite  = (src_q != SRC_RESET);
                end
                STEP_PUSH_PCL: begin
                    bus.stackSelect = SEL_PCL;
                    bus.stackWrite  = (src_q != SRC_RESET);
                end
                STEP_PUSH_P: begin
                    bus.stackSelect   = SEL_P;
                    bus.stackWrite    = (src_q != SRC_RESET);
                    bus.pushBreakFlag = (src_q == SRC_BRK);
                end
                STEP_VECTOR_LO: begin
                    bus.vectorFetch         = 1'b1;
                    bus.vectorAddress       = vec_base;
                    bus.setInterruptDisable = 1'b1;
                end
                STEP_VECTOR_HI: begin
                    bus.vectorFetch   = 1'b1;
                    bus.vectorAddress = vec_base + 16'd1;
                    bus.sequenceDone  = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu6502_interrupt_sequencer.sv
// tb/tb_cpu6502_interrupt_sequencer.sv - directed plus random checks against a queue-based entry model
module tb_cpu6502_interrupt_sequencer;

    typedef struct packed {
        logic        busy;
        logic [2:0]  step;
        logic        sw;
        logic [1:0]  sel;
        logic        pbf;
        logic        vf;
        logic [15:0] va;
        logic        inc;
        logic        sid;
        logic        done;
        logic        clr_nmi;
        logic        clr_rst;
        logic        irq_like;
    } rec_t;

    localparam int K_RESET = 0;
    localparam int K_NMI   = 1;
    localparam int K_IRQ   = 2;
    localparam int K_BRK   = 3;

    logic clock = 1'b0;
    logic reset_N = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;

    rec_t exp_q[$];
    bit   m_rst_pend;
    bit   m_nmi_pend;
    bit   m_nmi_prev;

    cpu6502_interrupt_sequencer_if bus();

    cpu6502_interrupt_sequencer dut (
        .clock   (clock),
        .reset_N (reset_N),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rst_pend = 1'b1;
        m_nmi_pend = 1'b0;
        m_nmi_prev = 1'b1;
    endtask

    task automatic push_seq(input int kind);
        logic [15:0] base;
        rec_t r;
        base = (kind == K_RESET) ? 16'hFFFC : (kind == K_NMI) ? 16'hFFFA : 16'hFFFE;
        for (int s = 0; s < 7; s++) begin
            r          = '0;
            r.busy     = 1'b1;
            r.step     = 3'(s);
            r.sw       = (s >= 2 && s <= 4 && kind != K_RESET);
            r.sel      = (s >= 2 && s <= 4) ? 2'(s - 2) : 2'd0;
            r.pbf      = (s == 4 && kind == K_BRK);
            r.vf       = (s >= 5);
            r.va       = (s == 6) ? base + 16'd1 : base;
            r.inc      = (s == 0 && kind == K_BRK);
            r.sid      = (s == 5);
            r.done     = (s == 6);
            r.clr_nmi  = (s == 4 && kind == K_NMI);
            r.clr_rst  = (s == 6 && kind == K_RESET);
            r.irq_like = (kind == K_IRQ || kind == K_BRK);
            exp_q.push_back(r);
        end
    endtask

    task automatic model_update();
        bit   clr = 1'b0;
        bit   old_nmi;
        rec_t r;
        old_nmi = m_nmi_pend;
        if (!reset_N) begin
            model_reset();
            return;
        end
        if (bus.enable) begin
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                clr = r.clr_nmi;
                if (r.clr_rst) m_rst_pend = 1'b0;
`ifdef CPU6502_NMI_HIJACK_EN
                if (old_nmi && r.irq_like && r.step <= 3'd3) begin
                    for (int i = 0; i < exp_q.size(); i++) begin
                        rec_t t;
                        t = exp_q[i];
                        if (t.step == 3'd4) t.clr_nmi = 1'b1;
                        if (t.step == 3'd5) t.va = 16'hFFFA;
                        if (t.step == 3'd6) t.va = 16'hFFFB;
                        exp_q[i] = t;
                    end
                end
`endif
            end else if (bus.instructionBoundary) begin
                if (m_rst_pend) push_seq(K_RESET);
                else if (old_nmi) push_seq(K_NMI);
                else if (!bus.interrupt_N && !bus.interruptDisableFlag) push_seq(K_IRQ);
                else if (bus.brkDecoded) push_seq(K_BRK);
            end
        end
        if (m_nmi_prev && !bus.nonMaskableInterrupt_N) m_nmi_pend = 1'b1;
        else if (clr) m_nmi_pend = 1'b0;
        m_nmi_prev = bus.nonMaskableInterrupt_N;
    endtask

    task automatic check_now();
        rec_t e;
        e = (exp_q.size() != 0) ? exp_q[0] : rec_t'(0);
        chk("busy", 16'(bus.busy), 16'(e.busy));
        chk("sequenceStep", 16'(bus.sequenceStep), 16'(e.step));
        chk("stackWrite", 16'(bus.stackWrite), 16'(e.sw));
        chk("stackSelect", 16'(bus.stackSelect), 16'(e.sel));
        chk("pushBreakFlag", 16'(bus.pushBreakFlag), 16'(e.pbf));
        chk("vectorFetch", 16'(bus.vectorFetch), 16'(e.vf));
        chk("incrementPc", 16'(bus.incrementPc), 16'(e.inc));
        chk("setInterruptDisable", 16'(bus.setInterruptDisable), 16'(e.sid));
        chk("sequenceDone", 16'(bus.sequenceDone), 16'(e.done));
        if (e.vf) chk("vectorAddress", bus.vectorAddress, e.va);
    endtask

    task automatic tick();
        #1;
        check_now();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_in(input logic en, input logic bnd, input logic irq_n,
                          input logic idf, input logic brk, input logic nmi_n);
        bus.enable                 = en;
        bus.instructionBoundary    = bnd;
        bus.interrupt_N            = irq_n;
        bus.interruptDisableFlag   = idf;
        bus.brkDecoded             = brk;
        bus.nonMaskableInterrupt_N = nmi_n;
    endtask

    task automatic reset_checks();
        #1;
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_step", 16'(bus.sequenceStep), 16'd0);
        chk("rst_vectorAddress", bus.vectorAddress, 16'hFFFC);
        chk("rst_stackWrite", 16'(bus.stackWrite), 16'd0);
        chk("rst_vectorFetch", 16'(bus.vectorFetch), 16'd0);
        chk("rst_sequenceDone", 16'(bus.sequenceDone), 16'd0);
    endtask

    initial begin
        logic nmi_v;
        set_in(1, 1, 1, 0, 0, 1);
        reset_N = 1'b0;
        model_reset();
        reset_checks();
        run(2);

        reset_N = 1'b1;
        run(9);

        set_in(1, 1, 0, 0, 0, 1);
        run(9);
        set_in(1, 1, 0, 1, 0, 1);
        run(3);

        set_in(1, 1, 1, 0, 1, 1);
        run(9);
        set_in(1, 1, 0, 0, 1, 1);
        run(9);

        set_in(1, 0, 1, 0, 0, 0);
        run(1);
        set_in(1, 0, 1, 0, 0, 1);
        run(2);
        set_in(1, 1, 1, 0, 0, 1);
        run(9);
        set_in(1, 1, 1, 0, 0, 0);
        run(20);

        set_in(1, 1, 1, 0, 0, 1);
        run(1);
        set_in(1, 1, 0, 0, 0, 1);
        run(2);
        set_in(1, 1, 0, 0, 0, 0);
        run(2);
        set_in(1, 0, 1, 0, 0, 0);
        run(16);

        set_in(1, 1, 0, 0, 0, 1);
        run(4);
        set_in(0, 1, 0, 0, 0, 1);
        run(3);
        set_in(1, 1, 0, 0, 0, 1);
        run(1);
        reset_N = 1'b0;
        model_reset();
        reset_checks();
        run(1);
        reset_N = 1'b1;
        set_in(1, 1, 1, 0, 0, 1);
        run(9);

        nmi_v = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(5) == 0) nmi_v = ~nmi_v;
            set_in(($urandom_range(7) != 0), 1'($urandom_range(1)), ($urandom_range(2) != 0),
                   1'($urandom_range(1)), ($urandom_range(3) == 0), nmi_v);
            if ($urandom_range(299) == 0) begin
                reset_N = 1'b0;
                model_reset();
            end else begin
                reset_N = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
